conv_result_collector: RTL and testbench

- Sink at the output end of the 3x3 convolution stream; captures each qualified pixel (y_in with w_en_in=1) of a 7x7 result frame into an internal 49-entry buffer in raster order.
- After the frame is complete, drains the buffer to a downstream consumer over a valid/ready read port, then waits to be re-armed.
- Flags samples that arrive when no capture is in progress.

---
 rtl/conv_result_collector.sv | 157 +++++++++++++++
 tb/tb_conv_result_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// -----------------------------------------------------------------------------
// conv_result_collector
//
// Sink at the end of the 3x3 convolution stream. Captures one OUT_W x OUT_H
// result frame, in raster order, into an internal buffer. Once the frame is
// complete, the block drains the buffer over a valid/ready read port. It then
// stays quiet until it is re-armed with start. A sample that arrives while no
// capture is in progress is dropped and raises a sticky overflow flag.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   y_in        convolution result sample (DATA_W)
//   w_en_in     sample-qualify strobe for y_in
//   start       single-cycle re-arm: clear pointers/flags, enter CAPTURE
//   rd_ready    consumer accepts rd_data this cycle
//   rd_valid    rd_data / rd_addr hold a buffered sample
//   rd_data     buffered sample (DATA_W)
//   rd_addr     raster index of rd_data (ADDR_W)
//   rd_last     rd_data is the final sample of the frame
//   frame_done  one-cycle pulse after the final sample is written
//   overflow    sticky: a sample was dropped outside CAPTURE
//   wr_count    samples captured in the current frame (ADDR_W+1)
// -----------------------------------------------------------------------------
module conv_result_collector #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 7,
  parameter int OUT_H  = 7,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_in,
  input  logic              w_en_in,
  input  logic              start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  localparam int                N        = OUT_W * OUT_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    ST_CAPTURE,
    ST_DRAIN,
    ST_IDLE
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [N];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_wr_count;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_last;
  logic                r_frame_done;
  logic                r_overflow;

  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_rd_next;

  // start outranks a simultaneous strobe: that sample is neither stored nor
  // treated as overflow.
  assign w_wr_en   = (r_state == ST_CAPTURE) && w_en_in && !start;
  assign w_rd_next = r_rd_ptr + ADDR_W'(1);

  // NOTE: the buffer has no reset. Its contents are only read after a full
  // frame has been written, so clearing it would buy nothing but reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= y_in;
  end

  // NOTE: all state uses non-blocking assignments, so every branch below sees
  // the values from before this edge. That is what lets rd_data pick up
  // mem[rd_ptr+1] in the same edge that rd_ptr advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_CAPTURE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wr_count   <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (start) begin
        r_state    <= ST_CAPTURE;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_wr_count <= '0;
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_en_in && (r_state != ST_CAPTURE)) r_overflow <= 1'b1;
        case (r_state)
          ST_CAPTURE: begin
            if (w_en_in) begin
              r_wr_count <= r_wr_count + (ADDR_W+1)'(1);
              // The final write forces DRAIN, so wr_ptr never wraps into a
              // partial frame; it parks at the last index.
              if (r_wr_ptr == LAST_IDX) begin
                r_frame_done <= 1'b1;
                r_state      <= ST_DRAIN;
              end else begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (!r_rd_valid) begin
              // First DRAIN cycle: prime the output register with entry 0.
              r_rd_valid <= 1'b1;
              r_rd_ptr   <= '0;
              r_rd_data  <= r_mem[0];
              r_rd_last  <= (LAST_IDX == '0);
            end else if (rd_ready) begin
              if (r_rd_last) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
                r_rd_ptr   <= '0;
                r_state    <= ST_IDLE;
              end else begin
                r_rd_ptr  <= w_rd_next;
                r_rd_data <= r_mem[w_rd_next];
                r_rd_last <= (w_rd_next == LAST_IDX);
              end
            end
          end
          ST_IDLE: begin
            // Quiet; the buffer is retained until start.
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign rd_addr    = r_rd_ptr;
  assign rd_last    = r_rd_last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_conv_result_collector.sv
// -----------------------------------------------------------------------------
// tb_conv_result_collector
//
// Directed testbench for conv_result_collector. The bench drives inputs and
// samples outputs on the falling edge. The DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_conv_result_collector;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int N      = 49;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] y_in;
  logic              w_en_in;
  logic              start;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W:0]   wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  conv_result_collector #(
    .DATA_W(DATA_W), .OUT_W(7), .OUT_H(7), .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .w_en_in    (w_en_in),
    .start      (start),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .rd_last    (rd_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle, optionally with a simultaneous strobe, and
  // check the re-armed state on the following falling edge.
  task automatic pulse_start(input logic with_wen);
    @(negedge clk);
    start = 1'b1; w_en_in = with_wen; y_in = 8'hFF;
    @(negedge clk);
    start = 1'b0; w_en_in = 1'b0;
    n_checks++;
    if (wr_count !== 7'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++;
      $display("FAIL start_rearm: wr_count=%0d rd_valid=%b overflow=%b rd_last=%b, want 0 0 0 0",
               wr_count, rd_valid, overflow, rd_last);
    end
  endtask

  // Write 49 samples base+i in bursts of 'burst' separated by 'gap' idle
  // cycles. Then check the frame_done pulse and wr_count.
  task automatic send_frame(input logic [7:0] base, input int burst, input int gap);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_done_early: sample %0d frame_done=%b want 0", i, frame_done);
      end
      w_en_in = 1'b1;
      y_in    = base + 8'(i);
      if ((i % burst) == burst - 1 && i != N - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          w_en_in = 1'b0;
        end
      end
    end
    @(negedge clk);
    w_en_in = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1 || wr_count !== 7'd49 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done: frame_done=%b wr_count=%0d rd_valid=%b, want 1 49 0",
               frame_done, wr_count, rd_valid);
    end
  endtask

  // Drain and check every sample. mode 0: rd_ready always 1. mode 1: rd_ready
  // follows 1,0,0,1,0,0,... A strobe with y_in=FF is injected on cycle
  // 'inject' (-1 = none). If stop_at >= 0, the task returns right after
  // checking the sample at that index, without accepting it.
  task automatic drain(input logic [7:0] base, input int mode, input int inject, input int stop_at);
    int  idx = 0;
    int  cyc = 0;
    bit  stopped = 0;
    bit  broke = 0;
    while (idx < N && cyc < 300 && !stopped && !broke) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_valid: idx %0d rd_valid=%b want 1", idx, rd_valid);
        broke = 1;
      end else begin
        if (rd_data !== base + 8'(idx) || rd_addr !== 6'(idx) || rd_last !== (idx == N - 1)) begin
          n_fail++;
          $display("FAIL drain_data: idx %0d got data=%h addr=%0d last=%b want data=%h addr=%0d last=%b",
                   idx, rd_data, rd_addr, rd_last, base + 8'(idx), idx, (idx == N - 1));
        end
        if (idx == stop_at) begin
          stopped = 1;
        end else begin
          w_en_in  = (cyc == inject);
          y_in     = 8'hFF;
          rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
          if (rd_ready) idx++;
          cyc++;
        end
      end
    end
    if (!stopped && !broke) begin
      @(negedge clk);
      rd_ready = 1'b0; w_en_in = 1'b0;
      n_checks++;
      if (idx != N || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_end: handshakes=%0d rd_valid=%b, want 49 0", idx, rd_valid);
      end
    end
    rd_ready = 1'b0; w_en_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; y_in = '0; w_en_in = 1'b0; start = 1'b0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rd_valid !== 0 || rd_data !== 0 || rd_addr !== 0 || rd_last !== 0 ||
        frame_done !== 0 || overflow !== 0 || wr_count !== 0) begin
      n_fail++;
      $display("FAIL reset: valid=%b data=%h addr=%0d last=%b fd=%b ovf=%b cnt=%0d, want all 0",
               rd_valid, rd_data, rd_addr, rd_last, frame_done, overflow, wr_count);
    end
    rst = 1'b1;
  endtask

  task automatic test_contiguous;
    send_frame(8'h00, N, 0);
    drain(8'h00, 0, -1, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: rd_valid=%b overflow=%b want 0 0", rd_valid, overflow);
    end
  endtask

  task automatic test_bursts;
    pulse_start(1'b0);
    send_frame(8'hA0, 7, 2);
    drain(8'hA0, 0, -1, -1);
  endtask

  task automatic test_back_pressure;
    pulse_start(1'b0);
    send_frame(8'h30, N, 0);
    drain(8'h30, 1, -1, -1);
  endtask

  task automatic test_overflow;
    pulse_start(1'b0);
    send_frame(8'h10, N, 0);
    drain(8'h10, 0, 5, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: overflow=%b want 1", overflow);
    end
    pulse_start(1'b0);
  endtask

  task automatic test_restart;
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      w_en_in = 1'b1; y_in = 8'h55 + 8'(i);
    end
    @(negedge clk);
    w_en_in = 1'b0;
    n_checks++;
    if (wr_count !== 7'd20) begin
      n_fail++;
      $display("FAIL partial_count: wr_count=%0d want 20", wr_count);
    end
    // start with a simultaneous strobe: the strobe must be ignored.
    pulse_start(1'b1);
    send_frame(8'h70, N, 0);
    drain(8'h70, 0, -1, -1);
  endtask

  task automatic test_reset_mid_drain;
    pulse_start(1'b0);
    send_frame(8'h20, N, 0);
    drain(8'h20, 0, -1, 10);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 0 || rd_data !== 0 || rd_addr !== 0 || rd_last !== 0 ||
        frame_done !== 0 || overflow !== 0 || wr_count !== 0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h addr=%0d last=%b fd=%b ovf=%b cnt=%0d, want all 0",
               rd_valid, rd_data, rd_addr, rd_last, frame_done, overflow, wr_count);
    end
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'h90, N, 0);
    drain(8'h90, 1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_bursts();
    test_back_pressure();
    test_overflow();
    test_restart();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
